// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, FSM state encoding and datapath select encodings
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_R  = 4'd3,
    S_WB_R    = 4'd4,
    S_EXEC_I  = 4'd5,
    S_WB_I    = 4'd6,
    S_ADDR    = 4'd7,
    S_MEM_RD  = 4'd8,
    S_MEM_WR  = 4'd9,
    S_WB_MEM  = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13,
    S_TRAP    = 4'd14
  } state_t;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] ALU_B_RT      = 2'd0;
  localparam logic [1:0] ALU_B_FOUR    = 2'd1;
  localparam logic [1:0] ALU_B_IMM     = 2'd2;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'd3;

  localparam logic [1:0] ALU_OP_ADD    = 2'd0;
  localparam logic [1:0] ALU_OP_SUB    = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'd2;

  // Dispatch target after DECODE; anything not listed is an illegal opcode.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:     return S_EXEC_R;
      OP_LW, OP_SW: return S_ADDR;
      OP_BEQ:       return S_BRANCH;
      OP_ADDI:      return S_EXEC_I;
      OP_J:         return S_JUMP;
      default:      return S_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// rtl/mips_ctrl_outdec.sv - combinational decode of FSM state into the datapath control word
module mips_ctrl_outdec
  import mips_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       busy,
  output logic       illegal
);

  state_t st;
  assign st = state_t'(state);

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALU_B_RT;
    alu_op     = ALU_OP_ADD;
    busy       = (st != S_IDLE) && (st != S_TRAP);
    illegal    = (st == S_ILLEGAL) || (st == S_TRAP);
    case (st)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALU_B_FOUR;
        // IR and PC latch only in the cycle memory returns the instruction.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = ALU_B_IMM_SH2;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
      end
      S_WB_I: reg_write = 1'b1;
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM; MIPS_CTRL_PERF_EN adds a retired-instruction counter
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int PERF_W       = 32,
  parameter int ILLEGAL_HALT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
`ifdef MIPS_CTRL_PERF_EN
  output logic [PERF_W-1:0] instr_retired,
`endif
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       busy,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_t state_q, state_d;

  // The ALU decoder owns funct; the sequencer deliberately ignores it.
  logic unused_funct;
  assign unused_funct = ^funct;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (run) state_d = S_FETCH;
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE:  state_d = decode_next(opcode);
      S_EXEC_R:  state_d = S_WB_R;
      S_EXEC_I:  state_d = S_WB_I;
      S_ADDR:    state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:  if (mem_ready) state_d = S_FETCH;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_ILLEGAL: state_d = (ILLEGAL_HALT != 0) ? S_TRAP : S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

`ifdef MIPS_CTRL_PERF_EN
  logic [PERF_W-1:0] instr_retired_q, instr_retired_d;
  logic              retire;

  // An illegal refetch is not a retirement, so ILLEGAL is excluded.
  always_comb begin
    retire = (state_d == S_FETCH) &&
             (state_q inside {S_WB_R, S_WB_I, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP});
    instr_retired_d = instr_retired_q + PERF_W'(retire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instr_retired_q <= '0;
    else        instr_retired_q <= instr_retired_d;
  end

  assign instr_retired = instr_retired_q;
`endif

  mips_ctrl_outdec u_outdec (
    .state      (state_q),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .busy       (busy),
    .illegal    (illegal)
  );

endmodule
